// File: rtl/tick_source_sel_if.sv
// Bundle of source inputs, select/clear controls and tick outputs for tick_source_sel.
// master drives the sources and requests; slave is the selector itself.
interface tick_source_sel_if #(
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 8
);
  logic [NUM_SRC-1:0] src_in;
  logic               sel_req;
  logic [SEL_W-1:0]   sel_new;
  logic               cnt_clr;
  logic               q_level;
  logic               tick;
  logic [SEL_W-1:0]   active_sel;
  logic               busy;
  logic               sel_err;
  logic [CNT_W-1:0]   tick_cnt;

  modport master (
    output src_in, sel_req, sel_new, cnt_clr,
    input  q_level, tick, active_sel, busy, sel_err, tick_cnt
  );

  modport slave (
    input  src_in, sel_req, sel_new, cnt_clr,
    output q_level, tick, active_sel, busy, sel_err, tick_cnt
  );
endinterface

// File: rtl/tick_source_sel.sv
// Glitch-free selector of NUM_SRC asynchronous timing sources: synchronises every
// source, delivers the chosen one as a level and a one-cycle tick, and counts ticks.
module tick_source_sel #(
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int BLANK_CYC   = 8,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_SEL = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  tick_source_sel_if.slave    bus
);

  localparam int BC_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BC_W-1:0]  BLANK_LOAD = BC_W'(BLANK_CYC - 1);
  localparam logic [SEL_W:0]   NUM_SRC_W  = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] SEL_RST    = SEL_W'(DEFAULT_SEL);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_BLANK,
    ST_ARM
  } state_t;

  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] prev_q;
  logic [NUM_SRC-1:0] sync_lvl;
  logic [NUM_SRC-1:0] rise;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [BC_W-1:0]  blank_q, blank_d;
  logic             q_level_q, q_level_d;
  logic             tick_q, tick_d;
  logic             busy_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             range_err;
  logic             accept;
  logic             cur_lvl;
  logic             nxt_lvl;
  logic             nxt_rise;

  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign rise     = sync_lvl & ~prev_q;

  // Edge detection runs for every source, so a freshly selected source
  // already has valid history when it becomes active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus.src_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_lvl;
    end
  end

  // NOTE: every variable assigned in this block gets a default first, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    cur_lvl  = 1'b0;
    nxt_lvl  = 1'b0;
    nxt_rise = 1'b0;
    state_d  = state_q;
    sel_d    = sel_q;
    blank_d  = blank_q;

    range_err = bus.sel_req && ({1'b0, bus.sel_new} >= NUM_SRC_W);
    accept    = bus.sel_req && !range_err &&
                !((state_q == ST_RUN) && (bus.sel_new == sel_q));

    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_q == SEL_W'(i)) cur_lvl = sync_lvl[i];
    end

    if (accept) begin
      sel_d   = bus.sel_new;
      state_d = ST_BLANK;
      blank_d = BLANK_LOAD;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (blank_q == '0) state_d = ST_ARM;
          else               blank_d = blank_q - BC_W'(1);
        end
        // Waiting for a low level means the first tick after a switch always
        // comes from a fresh rising edge, never from a level already high.
        ST_ARM: begin
          if (!cur_lvl) state_d = ST_RUN;
        end
        default: ;
      endcase
    end

    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel_d == SEL_W'(i)) begin
        nxt_lvl  = sync_lvl[i];
        nxt_rise = rise[i];
      end
    end

    q_level_d = (state_d == ST_RUN) && nxt_lvl;
    tick_d    = (state_d == ST_RUN) && nxt_rise;
    err_d     = range_err;
    cnt_d     = bus.cnt_clr ? CNT_W'(tick_q) : cnt_q + CNT_W'(tick_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      sel_q     <= SEL_RST;
      blank_q   <= '0;
      q_level_q <= 1'b0;
      tick_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      blank_q   <= blank_d;
      q_level_q <= q_level_d;
      tick_q    <= tick_d;
      busy_q    <= (state_d != ST_RUN);
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.q_level    = q_level_q;
  assign bus.tick       = tick_q;
  assign bus.active_sel = sel_q;
  assign bus.busy       = busy_q;
  assign bus.sel_err    = err_q;
  assign bus.tick_cnt   = cnt_q;

endmodule

// File: doc/tick_source_sel.md
Name: tick_source_sel

Overview:
- Parametrised successor to the microwave controller's two-input clock-entry selector.
- Takes NUM_SRC asynchronous timing sources (e.g. 1 Hz divider output, manual step pulse, test pulse) and synchronises each into the single system clock.
- Outputs the selected source as a clean level and a one-cycle tick, and counts delivered ticks.
- Source changes are glitch-free: a blanking window, then an arm phase that waits for a low level before output resumes.

Parameters:
- NUM_SRC, 4, number of source inputs (2..16)
- SEL_W, 2, width of select bus; must satisfy 2**SEL_W >= NUM_SRC
- SYNC_STAGES, 2, synchroniser flops per source (>=2)
- BLANK_CYC, 8, clock cycles of forced-low output after an accepted switch (>=1)
- CNT_W, 8, width of tick counter
- DEFAULT_SEL, 0, source selected out of reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- src_in  in  NUM_SRC  asynchronous source levels; bit i = source i
- sel_req  in  1  one-cycle request to switch to sel_new
- sel_new  in  SEL_W  requested source index
- cnt_clr  in  1  synchronous clear of tick_cnt
- q_level  out  1  synchronised level of the active source; 0 while busy
- tick  out  1  one-cycle pulse per rising edge of the active source
- active_sel  out  SEL_W  currently selected index
- busy  out  1  high in BLANK and ARM states
- sel_err  out  1  one-cycle pulse when a request is rejected as out of range
- tick_cnt  out  CNT_W  ticks delivered since reset/clear; wraps

Behaviour:
- Reset (rst_n=0 at a clk edge): all synchroniser and previous-level flops=0; state=RUN; active_sel=DEFAULT_SEL; q_level=0, tick=0, busy=0, sel_err=0, tick_cnt=0.
- Per source: SYNC_STAGES-flop synchroniser, then a previous-level flop. Rising-edge detect = sync & ~prev. Detection runs continuously for all sources, independent of selection.
- Latency: with src_in[active] rising before clk edge k:
  - q_level rises after edge k+SYNC_STAGES-1+1, i.e. registered.
  - tick is high for exactly the cycle following edge k+SYNC_STAGES.
  - Default: the pulse is visible after the 3rd edge.
  - tick and q_level are both registered outputs.
- States:
  - RUN: q_level = synchronised active level; tick = edge pulse of active source.
  - BLANK: q_level=0, tick=0; blank counter decrements each cycle from BLANK_CYC-1; at 0 -> ARM.
  - ARM: q_level=0, tick=0; when the synchronised level of active_sel is 0 -> RUN (same edge). If the source is held high, the block stays in ARM indefinitely.
- sel_req handling, evaluated in every state:
  - sel_new >= NUM_SRC: sel_err=1 for one cycle; no other effect.
  - state=RUN and sel_new == active_sel: ignored, no error.
  - Otherwise: active_sel <= sel_new; state <= BLANK; blank counter reloaded. A request during BLANK/ARM restarts the blanking; latest request wins, including a request back to the old source.
- busy is registered and goes high the cycle after an accepted sel_req.
- tick_cnt:
  - Increments by 1 on each cycle tick=1; wraps 2**CNT_W-1 -> 0.
  - cnt_clr alone -> 0 next cycle.
  - cnt_clr and tick in the same cycle -> 1.
- No tick is ever produced in the first cycle of RUN from a stale edge. The ARM low-level condition guarantees the next tick needs a fresh rising edge.
- Reset asserted mid-BLANK/ARM: returns to RUN on DEFAULT_SEL with all outputs at reset values.

Test Plan:
- Reset, NUM_SRC=4, src_in=0, then pulse src_in[0] high for 4 cycles -> tick=1 for one cycle, 3 edges after rise; q_level high 4 cycles; tick_cnt=1.
- sel_req with sel_new=2 while src_in[2]=1 held -> busy=1, q_level=0 for 8 cycles of BLANK, then stays in ARM. Drop src_in[2] -> RUN. Next rise of src_in[2] gives tick; edges on src_in[0] give none.
- sel_new=2 at cycle 0, sel_new=1 at cycle 3 of BLANK -> active_sel=1; BLANK restarts; busy lasts >= 8 cycles from the second request.
- Out-of-range request with NUM_SRC=3, SEL_W=2, sel_new=3 -> sel_err pulses once; active_sel, busy and tick_cnt unchanged.
- CNT_W=4, 16 ticks -> tick_cnt wraps 15 -> 0. cnt_clr coincident with a tick -> 1. cnt_clr alone -> 0.
- rst_n=0 asserted during BLANK with active_sel=3 -> next cycle active_sel=0, busy=0, tick_cnt=0, q_level=0.
